// File: rtl/scs8hd_tester_pkg.sv
// Shared types and constants for the 2-input cell tester.
// Vector ordering helper covers both the binary order and the Gray order
// selected by SCS8HD_TESTER_GRAY_EN.
package scs8hd_tester_pkg;

  localparam int VEC_W = 2;

  // Expected-Y truth tables; bit n is the expected Y for vector {A,B}=n.
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_SAMPLE  = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } state_e;

  typedef struct packed {
    logic [VEC_W-1:0] vec;   // successor vector
    logic             last;  // input vector is the last of the order
  } vec_nxt_t;

  // Successor in the selected order. Gray: 00,01,11,10 then wraps to 00.
  function automatic vec_nxt_t next_vec(input logic [VEC_W-1:0] vec, input logic gray);
    vec_nxt_t r;
    if (gray) begin
      case (vec)
        2'b00:   r.vec = 2'b01;
        2'b01:   r.vec = 2'b11;
        2'b11:   r.vec = 2'b10;
        default: r.vec = 2'b00;
      endcase
      r.last = (vec == 2'b10);
    end else begin
      r.vec  = vec + 2'b01;
      r.last = (vec == 2'b11);
    end
    return r;
  endfunction

endpackage

// File: rtl/scs8hd_tester_vecgen.sv
// Vector register, vector ordering and loop counter for the tester.
// Define SCS8HD_TESTER_GRAY_EN for Gray order (00,01,11,10); default is binary.
module scs8hd_tester_vecgen
  import scs8hd_tester_pkg::*;
#(
  parameter int LOOPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,        // run accepted: restart at vector 0, loop 0
  input  logic             adv_i,        // step to the next vector / loop
  output logic [VEC_W-1:0] vec_o,
  output logic             last_vec_o,   // current vector is last in the order
  output logic             loop_done_o   // current loop is the final one
);

`ifdef SCS8HD_TESTER_GRAY_EN
  localparam logic GRAY = 1'b1;
`else
  localparam logic GRAY = 1'b0;
`endif

  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       loop_q, loop_d;
  vec_nxt_t         nxt;

  assign nxt         = next_vec(vec_q, GRAY);
  assign vec_o       = vec_q;
  assign last_vec_o  = nxt.last;
  assign loop_done_o = (loop_q == LOOP_LAST);

  // Next vector/loop: wrap to the first vector on a new loop, hold after the final one.
  always_comb begin
    vec_d  = vec_q;
    loop_d = loop_q;
    if (clr_i) begin
      vec_d  = '0;
      loop_d = '0;
    end else if (adv_i) begin
      if (nxt.last) begin
        if (!loop_done_o) begin
          loop_d = loop_q + 8'd1;
          vec_d  = '0;
        end
      end else begin
        vec_d = nxt.vec;
      end
    end
  end

  // Vector and loop state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      loop_q <= '0;
    end else begin
      vec_q  <= vec_d;
      loop_q <= loop_d;
    end
  end

endmodule

// File: rtl/scs8hd_gate2_tester.sv
// Stimulus/response checker for 2-input combinational cells.
// Drives every {A,B} vector, waits SETTLE_CYC cycles, samples Y against
// EXPECT_TT and accumulates a saturating mismatch count.
// Define SCS8HD_TESTER_GRAY_EN to walk vectors in Gray order.
module scs8hd_gate2_tester
  import scs8hd_tester_pkg::*;
#(
  parameter int         SETTLE_CYC = 2,
  parameter int         LOOPS      = 1,
  parameter logic [3:0] EXPECT_TT  = TT_NOR2
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       START,
  output logic       A_DRV,
  output logic       B_DRV,
  input  logic       Y_OBS,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [7:0] ERR_CNT,
  output logic [1:0] FAIL_VEC
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [VEC_W-1:0] ab_q, ab_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [1:0]       fv_q, fv_d;
  logic             vg_clr, vg_adv, last_vec, loop_done;
  logic [VEC_W-1:0] vec;

  scs8hd_tester_vecgen #(.LOOPS(LOOPS)) u_vecgen (
    .clk        (CLK),
    .rst_n      (RESETB),
    .clr_i      (vg_clr),
    .adv_i      (vg_adv),
    .vec_o      (vec),
    .last_vec_o (last_vec),
    .loop_done_o(loop_done)
  );

  assign A_DRV    = ab_q[1];
  assign B_DRV    = ab_q[0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fv_q;

  // Run sequencer: drive, settle, sample/compare, advance, finish.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ab_d     = ab_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    vg_clr   = 1'b0;
    vg_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // START is only seen here, so pulses while busy are ignored.
        if (START) begin
          state_d = S_DRIVE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = '0;
          vg_clr  = 1'b1;
        end
      end
      S_DRIVE: begin
        ab_d     = vec;
        settle_d = SETTLE_LD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) state_d = S_SAMPLE;
        else                  settle_d = settle_q - 4'd1;
      end
      S_SAMPLE: begin
        if (Y_OBS != EXPECT_TT[vec]) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          // A zero count means this is the first mismatch of the run.
          if (err_q == 8'd0)  fv_d  = vec;
        end
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        vg_adv  = 1'b1;
        state_d = (last_vec && loop_done) ? S_FINISH : S_DRIVE;
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 8'd0);
        ab_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any run in progress.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      ab_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
    end
  end

endmodule

// File: tb/tb_scs8hd_gate2_tester.sv
// Bench for scs8hd_gate2_tester: four instances (defaults, LOOPS=100,
// SETTLE_CYC=4, SETTLE_CYC=1) with a scoreboard per instance checked on DONE.
module tb_scs8hd_gate2_tester;

  typedef struct {
    logic       pass;
    logic [7:0] err;
    logic [1:0] fv;
    int         cyc;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_w [4];
  logic       done_w  [4];
  logic       pass_w  [4];
  logic       busy_w  [4];
  logic       a_w     [4];
  logic       b_w     [4];
  logic       y_w     [4];
  logic [7:0] err_w   [4];
  logic [1:0] fv_w    [4];
  logic       done_prev [4];

  res_t sbq [4][$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ymode = 0;   // dut0 Y source: 0 ideal NOR2, 1 stuck 0, 2 stuck 1

`ifdef SCS8HD_TESTER_GRAY_EN
  logic [1:0] ord [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
  logic [1:0] ord [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif

  // Cell models: dut0 ideal/stuck, dut1 stuck 1, dut2/dut3 NOR2 delayed 3 cycles.
  logic [2:0] p2 = 3'b111;
  logic [2:0] p3 = 3'b111;
  always @(posedge clk) begin
    p2 <= {p2[1:0], ~(a_w[2] | b_w[2])};
    p3 <= {p3[1:0], ~(a_w[3] | b_w[3])};
  end
  assign y_w[0] = (ymode == 0) ? ~(a_w[0] | b_w[0]) : (ymode == 2);
  assign y_w[1] = 1'b1;
  assign y_w[2] = p2[2];
  assign y_w[3] = p3[2];

  scs8hd_gate2_tester u0 (
    .CLK(clk), .RESETB(rstn), .START(start_w[0]), .A_DRV(a_w[0]), .B_DRV(b_w[0]),
    .Y_OBS(y_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .PASS(pass_w[0]),
    .ERR_CNT(err_w[0]), .FAIL_VEC(fv_w[0]));
  scs8hd_gate2_tester #(.LOOPS(100)) u1 (
    .CLK(clk), .RESETB(rstn), .START(start_w[1]), .A_DRV(a_w[1]), .B_DRV(b_w[1]),
    .Y_OBS(y_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .PASS(pass_w[1]),
    .ERR_CNT(err_w[1]), .FAIL_VEC(fv_w[1]));
  scs8hd_gate2_tester #(.SETTLE_CYC(4)) u2 (
    .CLK(clk), .RESETB(rstn), .START(start_w[2]), .A_DRV(a_w[2]), .B_DRV(b_w[2]),
    .Y_OBS(y_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]), .PASS(pass_w[2]),
    .ERR_CNT(err_w[2]), .FAIL_VEC(fv_w[2]));
  scs8hd_gate2_tester #(.SETTLE_CYC(1)) u3 (
    .CLK(clk), .RESETB(rstn), .START(start_w[3]), .A_DRV(a_w[3]), .B_DRV(b_w[3]),
    .Y_OBS(y_w[3]), .BUSY(busy_w[3]), .DONE(done_w[3]), .PASS(pass_w[3]),
    .ERR_CNT(err_w[3]), .FAIL_VEC(fv_w[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: on each DONE rising edge pop the expected result and compare.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_w[i] && !done_prev[i]) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("dut%0d unexpected DONE", i), 32'd1, 32'd0);
        end else begin
          chk($sformatf("dut%0d PASS", i),     32'(pass_w[i]), 32'(sbq[i][0].pass));
          chk($sformatf("dut%0d ERR_CNT", i),  32'(err_w[i]),  32'(sbq[i][0].err));
          chk($sformatf("dut%0d FAIL_VEC", i), 32'(fv_w[i]),   32'(sbq[i][0].fv));
          chk($sformatf("dut%0d DONE cycle", i), 32'(cyc),     32'(sbq[i][0].cyc));
          void'(sbq[i].pop_front());
        end
      end
      done_prev[i] <= done_w[i];
    end
  end

  // One-cycle START pulse; sc is the cycle count at the pulse.
  task automatic pulse(input int i, output int sc);
    @(negedge clk);
    sc = cyc;
    start_w[i] = 1'b1;
    @(negedge clk);
    start_w[i] = 1'b0;
  endtask

  // Pulse START and push the expected result; DONE rises len cycles after START edge.
  task automatic run(input int i, input logic p, input logic [7:0] e, input logic [1:0] f,
                     input int len, output int sc);
    res_t r;
    @(negedge clk);
    sc = cyc;
    r.pass = p; r.err = e; r.fv = f; r.cyc = cyc + len + 1;
    sbq[i].push_back(r);
    start_w[i] = 1'b1;
    @(negedge clk);
    start_w[i] = 1'b0;
  endtask

  task automatic wait_empty(input int i, input int bound);
    int k = 0;
    while (sbq[i].size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (sbq[i].size() != 0) begin
      chk($sformatf("dut%0d DONE timeout", i), 32'd0, 32'd1);
      sbq[i].delete();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " BUSY"},     32'(busy_w[0]), 32'd0);
    chk({tag, " DONE"},     32'(done_w[0]), 32'd0);
    chk({tag, " PASS"},     32'(pass_w[0]), 32'd0);
    chk({tag, " ERR_CNT"},  32'(err_w[0]),  32'd0);
    chk({tag, " FAIL_VEC"}, 32'(fv_w[0]),   32'd0);
    chk({tag, " A_DRV"},    32'(a_w[0]),    32'd0);
    chk({tag, " B_DRV"},    32'(b_w[0]),    32'd0);
  endtask

  initial begin
    int sc;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) start_w[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Ideal NOR2: vector order, and a START pulse while busy that must not disturb timing.
    ymode = 0;
    run(0, 1'b1, 8'd0, 2'b00, 21, sc);
    for (int k = 0; k < 4; k++) begin
      while (cyc < sc + 3 + 5 * k) @(negedge clk);
      chk($sformatf("vector %0d {A,B}", k), 32'({a_w[0], b_w[0]}), 32'(ord[k]));
      if (k == 1) begin
        chk("BUSY mid-run", 32'(busy_w[0]), 32'd1);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
      end
    end
    wait_empty(0, 100);

    // Stuck-at-0: only vector 00 mismatches. START while DONE=1 restarts.
    ymode = 1;
    run(0, 1'b0, 8'd1, 2'b00, 21, sc);
    chk("DONE cleared by restart", 32'(done_w[0]), 32'd0);
    wait_empty(0, 100);

    // Stuck-at-1: vectors 01, 10, 11 mismatch; first is 01.
    ymode = 2;
    run(0, 1'b0, 8'd3, 2'b01, 21, sc);
    wait_empty(0, 100);

    // Saturation, and settle time versus a 3-cycle-late cell.
    run(1, 1'b0, 8'd255, 2'b01, 2001, sc);
    run(2, 1'b1, 8'd0,   2'b00, 29,   sc);
    run(3, 1'b0, 8'd1,   2'b01, 17,   sc);
    wait_empty(1, 2100);
    wait_empty(2, 100);
    wait_empty(3, 100);

    // Abort during the settle of the third vector.
    ymode = 2;
    pulse(0, sc);
    while (cyc < sc + 13) @(negedge clk);
    chk("pre-abort BUSY",    32'(busy_w[0]), 32'd1);
    chk("pre-abort ERR_CNT", 32'(err_w[0]),  32'd1);
    chk("pre-abort A_DRV",   32'(a_w[0]),    32'd1);
    rstn = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    ymode = 0;
    run(0, 1'b1, 8'd0, 2'b00, 21, sc);
    wait_empty(0, 100);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scs8hd_gate2_tester.md
Name: scs8hd_gate2_tester

Overview:
- Sequential stimulus and response checker for 2-input combinational cells such as the NOR2 family.
- Drives A/B through every input vector, waits a programmable settle time, samples Y and compares it with an expected truth table.
- Accumulates mismatches and reports pass/fail.
- Sits on the cell-library test harness, at the other end of the A/B→Y interface from the cell under test.

Parameters:
- SETTLE_CYC, 2, cycles between driving a vector and sampling Y; legal range 1..15.
- LOOPS, 1, number of full passes over all 4 vectors; legal range 1..255.
- EXPECT_TT, 4'b0001, expected Y for vector index {A,B}; bit n is the expected Y for vector n. The default is NOR2.

Ports:
- CLK  input  1  rising-edge clock.
- RESETB  input  1  asynchronous active-low reset.
- START  input  1  single-cycle request to begin a run; ignored while BUSY=1.
- A_DRV  output  1  stimulus to the cell A pin.
- B_DRV  output  1  stimulus to the cell B pin.
- Y_OBS  input  1  cell Y output; synchronous to the CLK domain through the harness.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  high from the end of a run until the next accepted START.
- PASS  output  1  valid while DONE=1; 1 when ERR_CNT==0.
- ERR_CNT  output  8  saturating mismatch count for the current run.
- FAIL_VEC  output  2  {A,B} of the first mismatching vector; holds 2'b00 if there were no errors.

Behaviour:
- Reset (RESETB low, asynchronous): state=IDLE; A_DRV=0, B_DRV=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0; all counters cleared.
- Asserting RESETB mid-run aborts immediately; no partial result is retained.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, ADVANCE, FINISH.
- IDLE:
  - START=1 → DRIVE.
  - Clears ERR_CNT, FAIL_VEC, DONE and PASS; clears the vector and loop counters; sets BUSY=1 in the same edge.
- DRIVE (1 cycle):
  - Registers {A_DRV,B_DRV}=vec.
  - Loads the settle counter with SETTLE_CYC-1 → SETTLE.
- SETTLE: decrements each cycle; at 0 → SAMPLE. Total time from the DRIVE edge to the SAMPLE edge is SETTLE_CYC+1 cycles.
- SAMPLE (1 cycle):
  - Compares Y_OBS against EXPECT_TT[vec].
  - On mismatch, ERR_CNT increments, saturating at 8'hFF.
  - If this is the first mismatch, FAIL_VEC captures vec.
  - → ADVANCE.
- ADVANCE:
  - If vec is the last vector of the order: if the loop counter equals LOOPS-1 → FINISH; otherwise increment the loop counter, reset vec to the first vector, → DRIVE.
  - Otherwise step vec to the next vector → DRIVE.
- FINISH (1 cycle):
  - BUSY=0, DONE=1, PASS=(ERR_CNT==0).
  - A_DRV/B_DRV return to 0 → IDLE.
- Default vector order is binary: 00, 01, 10, 11.
- Run length is LOOPS×4×(SETTLE_CYC+3)+1 cycles from START to DONE rising.
- START held high or re-pulsed while BUSY=1 has no effect.
- START in the same cycle DONE is already high restarts the run and clears the results.
- A_DRV/B_DRV change only in DRIVE and FINISH, so stimulus is glitch-free registered outputs.

Optional Feature:
- Macro: SCS8HD_TESTER_GRAY_EN.
- Defined: the vector order is Gray code, 00, 01, 11, 10, so exactly one input toggles per step; this exercises single-input arcs for the specify-path checks. Loop wrap 10→00 is also a single toggle.
- Undefined: binary order, as in Behaviour.
- Result semantics, timing and FAIL_VEC encoding ({A,B} actual values) are identical in both builds.

Decomposition:
- Package scs8hd_tester_pkg:
  - FSM state enum.
  - VEC_W=2 constant.
  - Truth-table constants TT_NOR2=4'b0001, TT_NAND2=4'b0111, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110.
  - Function next_vec(vec, gray) returning the successor and a last flag.
- One sub-module, scs8hd_tester_vecgen: vector register, ordering, last-vector and loop-count logic. The top level holds the FSM, settle counter, compare and result registers.

Test Plan:
- Ideal NOR2 model on A/B→Y, defaults, START pulse → DONE after 4×5+1=21 cycles; PASS=1, ERR_CNT=0, FAIL_VEC=00.
- Y_OBS tied to 0 with the NOR2 table → ERR_CNT=1, FAIL_VEC=00, PASS=0; tied to 1 → ERR_CNT=3, FAIL_VEC=01.
- LOOPS=100, Y_OBS stuck at 1 → ERR_CNT=255 (saturated), not 300; PASS=0.
- SETTLE_CYC=4 with the model delayed by 3 cycles → PASS=1; the same model with SETTLE_CYC=1 → ERR_CNT>0.
- RESETB low during SETTLE of the 3rd vector → all outputs at reset values immediately. A new START then gives a clean run with PASS=1.
- SCS8HD_TESTER_GRAY_EN defined, monitor A_DRV/B_DRV → sequence 00, 01, 11, 10 with exactly one bit changing per DRIVE. START pulsed while BUSY → ignored, DONE timing unchanged.
